// File: rtl/flood_reveal_ctrl.sv
// flood_reveal_ctrl
// -----------------
// Reveal sequencer for an 8x8 minesweeper board. A reveal request on a
// tile with a non-zero adjacent count writes just that tile. A request on a
// zero tile walks the connected zero region breadth-first through an
// internal FIFO. Every region tile and its numbered border is written
// exactly once. Revealing a mine raises a one-cycle hit_mine and a sticky
// game_over.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           reveal request pulse (honoured only when idle and not game over)
//   start_index     tile to reveal, index = y*GRID_SIZE + x
//   mine_map        per-tile mine bitmap
//   adj             4-bit adjacent-mine count per tile
//   flagged         per-tile flag bitmap
//   revealed_in     per-tile reveal bitmap from tile storage
//   reveal_we       registered write strobe into tile storage
//   reveal_idx      tile index for reveal_we (holds while reveal_we is low)
//   busy            high while a request is in progress
//   done            one-cycle completion pulse
//   hit_mine        one-cycle pulse with the mine's reveal_we
//   game_over       sticky, cleared only by rst
//
// The neighbour arithmetic relies on GRID_SIZE being a power of two. An
// off-grid coordinate then shows up as the carry/borrow bit of the widened
// coordinate.
module flood_reveal_ctrl #(
  parameter int GRID_SIZE = 8,
  parameter int TILES     = GRID_SIZE * GRID_SIZE,
  parameter int IDX_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   start_index,
  input  logic [TILES-1:0]   mine_map,
  input  logic [4*TILES-1:0] adj,
  input  logic [TILES-1:0]   flagged,
  input  logic [TILES-1:0]   revealed_in,
  output logic               reveal_we,
  output logic [IDX_W-1:0]   reveal_idx,
  output logic               busy,
  output logic               done,
  output logic               hit_mine,
  output logic               game_over
);

  localparam int CW = $clog2(GRID_SIZE);

  localparam logic [CW:0] OFF_M1 = {(CW+1){1'b1}};
  localparam logic [CW:0] OFF_Z  = {(CW+1){1'b0}};
  localparam logic [CW:0] OFF_P1 = {{CW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r, state_s;

  logic [IDX_W-1:0]   fifo_mem_r [TILES];
  logic [IDX_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [TILES-1:0]   visited_r;
  logic [IDX_W-1:0]   cur_idx_r;
  logic [2:0]         nbr_r, nbr_s;

  logic               reveal_we_r;
  logic [IDX_W-1:0]   reveal_idx_r;
  logic               busy_r, done_r, hit_mine_r, game_over_r;

  logic               fifo_empty_s;
  logic [IDX_W-1:0]   head_s;
  logic [3:0]         head_adj_s;
  logic [CW:0]        dx_s, dy_s, nx_s, ny_s;
  logic               nbr_valid_s, nbr_ok_s;
  logic [IDX_W-1:0]   nbr_idx_s;

  logic               push_s, pop_s, we_s, hit_s, clear_vis_s, load_cur_s;
  logic [IDX_W-1:0]   push_idx_s, we_idx_s;
  logic [TILES-1:0]   push_onehot_s;

  // The FIFO is empty in IDLE, and at most TILES-1 entries are held at
  // once, so the pointers never have to be cleared per request and
  // equality is an unambiguous empty test.
  assign fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign head_adj_s    = adj[{head_s, 2'b00} +: 4];
  assign push_onehot_s = {{(TILES-1){1'b0}}, 1'b1} << push_idx_s;

  // Neighbour offset for scan step nbr_r, row by row from the top-left.
  always_comb begin
    dx_s = OFF_Z;
    dy_s = OFF_Z;
    case (nbr_r)
      3'd0:    begin dx_s = OFF_M1; dy_s = OFF_M1; end
      3'd1:    begin dx_s = OFF_Z;  dy_s = OFF_M1; end
      3'd2:    begin dx_s = OFF_P1; dy_s = OFF_M1; end
      3'd3:    begin dx_s = OFF_M1; dy_s = OFF_Z;  end
      3'd4:    begin dx_s = OFF_P1; dy_s = OFF_Z;  end
      3'd5:    begin dx_s = OFF_M1; dy_s = OFF_P1; end
      3'd6:    begin dx_s = OFF_Z;  dy_s = OFF_P1; end
      3'd7:    begin dx_s = OFF_P1; dy_s = OFF_P1; end
      default: begin dx_s = OFF_Z;  dy_s = OFF_Z;  end
    endcase
  end

  // Both -1 and GRID_SIZE set the top bit of the widened coordinate, so
  // the top bit alone rejects off-grid neighbours without wrap-around.
  assign nx_s        = {1'b0, cur_idx_r[CW-1:0]} + dx_s;
  assign ny_s        = {1'b0, cur_idx_r[IDX_W-1:CW]} + dy_s;
  assign nbr_valid_s = ~nx_s[CW] & ~ny_s[CW];
  assign nbr_idx_s   = {ny_s[CW-1:0], nx_s[CW-1:0]};
  assign nbr_ok_s    = nbr_valid_s & ~visited_r[nbr_idx_s] & ~flagged[nbr_idx_s]
                     & ~revealed_in[nbr_idx_s] & ~mine_map[nbr_idx_s];

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_s     = state_r;
    nbr_s       = nbr_r;
    push_s      = 1'b0;
    push_idx_s  = start_index;
    pop_s       = 1'b0;
    we_s        = 1'b0;
    we_idx_s    = reveal_idx_r;
    hit_s       = 1'b0;
    clear_vis_s = 1'b0;
    load_cur_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !game_over_r) begin
          clear_vis_s = 1'b1;
          if (flagged[start_index] || revealed_in[start_index]) begin
            state_s = DONE;
          end else if (mine_map[start_index]) begin
            we_s     = 1'b1;
            we_idx_s = start_index;
            hit_s    = 1'b1;
            state_s  = DONE;
          end else begin
            push_s     = 1'b1;
            push_idx_s = start_index;
            state_s    = POP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      POP: begin
        if (fifo_empty_s) begin
          state_s = DONE;
        end else begin
          pop_s      = 1'b1;
          we_s       = 1'b1;
          we_idx_s   = head_s;
          load_cur_s = 1'b1;
          if (head_adj_s != 4'd0) begin
            state_s = POP;
          end else begin
            state_s = SCAN;
            nbr_s   = 3'd0;
          end
        end
      end
      SCAN: begin
        push_s     = nbr_ok_s;
        push_idx_s = nbr_idx_s;
        if (nbr_r == 3'd7) begin
          state_s = POP;
          nbr_s   = 3'd0;
        end else begin
          state_s = SCAN;
          nbr_s   = nbr_r + 3'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      fifo_mem_r[wr_ptr_r] <= push_idx_s;
    end
  end

  // State, FIFO pointers, visited mask and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      nbr_r        <= 3'd0;
      wr_ptr_r     <= {IDX_W{1'b0}};
      rd_ptr_r     <= {IDX_W{1'b0}};
      visited_r    <= {TILES{1'b0}};
      cur_idx_r    <= {IDX_W{1'b0}};
      reveal_we_r  <= 1'b0;
      reveal_idx_r <= {IDX_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      hit_mine_r   <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      nbr_r   <= nbr_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      visited_r <= (clear_vis_s ? {TILES{1'b0}} : visited_r)
                 | (push_s ? push_onehot_s : {TILES{1'b0}});
      if (load_cur_s) begin
        cur_idx_r <= head_s;
      end
      reveal_we_r  <= we_s;
      reveal_idx_r <= we_idx_s;
      busy_r       <= (state_s != IDLE);
      done_r       <= (state_s == DONE);
      hit_mine_r   <= hit_s;
      game_over_r  <= game_over_r | hit_s;
    end
  end

  assign reveal_we  = reveal_we_r;
  assign reveal_idx = reveal_idx_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign hit_mine   = hit_mine_r;
  assign game_over  = game_over_r;

endmodule

// File: tb/tb_flood_reveal_ctrl.sv
// Bench for flood_reveal_ctrl: a coordinate-level breadth-first flood model
// predicts the ordered reveal list, the cycle of every write and the cycle
// of done. Directed boards and random boards run through the model.
module tb_flood_reveal_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   start_index;
  logic [63:0]  mine_map;
  logic [255:0] adj;
  logic [63:0]  flagged;
  logic [63:0]  revealed_in;
  logic         reveal_we;
  logic [5:0]   reveal_idx;
  logic         busy, done, hit_mine, game_over;
  logic         clear_rev;

  int total = 0;
  int bad   = 0;
  int exp_go = 0;

  int exp_idx[$];
  int exp_t[$];
  int exp_done;
  int exp_hit;

  always #5 clk = ~clk;

  flood_reveal_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_index (start_index),
    .mine_map    (mine_map),
    .adj         (adj),
    .flagged     (flagged),
    .revealed_in (revealed_in),
    .reveal_we   (reveal_we),
    .reveal_idx  (reveal_idx),
    .busy        (busy),
    .done        (done),
    .hit_mine    (hit_mine),
    .game_over   (game_over)
  );

  // Tile state storage: a write shows up in revealed_in one cycle later and
  // survives rst.
  always @(posedge clk) begin
    if (clear_rev) revealed_in <= 64'd0;
    else if (reveal_we) revealed_in[reveal_idx] <= 1'b1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int adj_of(input int i);
    return int'(adj[i*4 +: 4]);
  endfunction

  // Adjacent-mine counts consistent with mine_map.
  task automatic compute_adj();
    int c, nx, ny;
    for (int i = 0; i < 64; i++) begin
      c = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          nx = i % 8 + dx;
          ny = i / 8 + dy;
          if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
            c += int'(mine_map[ny*8 + nx]);
        end
      adj[i*4 +: 4] = 4'(c);
    end
  endtask

  // Breadth-first flood on (x,y) coordinates. Timing: first pop one cycle
  // after acceptance, each write one cycle after its pop, 1 cycle per
  // numbered tile, 9 per zero tile, then an empty pop and done.
  task automatic build_model(input int s);
    int q[$];
    bit vis[64];
    int t, i, x, y, nx, ny, n;
    exp_idx.delete();
    exp_t.delete();
    exp_hit = 0;
    if (flagged[s] || revealed_in[s]) begin
      exp_done = 1;
    end else if (mine_map[s]) begin
      exp_idx.push_back(s);
      exp_t.push_back(1);
      exp_hit  = 1;
      exp_done = 1;
    end else begin
      for (int k = 0; k < 64; k++) vis[k] = 1'b0;
      vis[s] = 1'b1;
      q.push_back(s);
      t = 1;
      while (q.size() > 0) begin
        i = q.pop_front();
        exp_idx.push_back(i);
        exp_t.push_back(t + 1);
        if (adj_of(i) != 0) begin
          t += 1;
        end else begin
          x = i % 8;
          y = i / 8;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              nx = x + dx;
              ny = y + dy;
              if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
                n = ny * 8 + nx;
                if (!vis[n] && !flagged[n] && !revealed_in[n] && !mine_map[n]) begin
                  vis[n] = 1'b1;
                  q.push_back(n);
                end
              end
            end
          t += 9;
        end
      end
      exp_done = t + 1;
    end
    if (exp_hit != 0) exp_go = 1;
  endtask

  task automatic clear_board();
    @(negedge clk);
    clear_rev = 1'b1;
    @(negedge clk);
    clear_rev = 1'b0;
  endtask

  // Issue one request and compare everything the DUT does against the model.
  task automatic run_req(input string tag, input int s);
    int got_idx[$];
    int got_t[$];
    int rel, done_rel, hit_n, busy_n, nk;
    build_model(s);
    @(negedge clk);
    start       = 1'b1;
    start_index = 6'(s);
    rel = 0; done_rel = -1; hit_n = 0; busy_n = 0;
    while (done_rel < 0 && rel < 900) begin
      @(negedge clk);
      rel++;
      start = 1'b0;
      if (reveal_we) begin
        got_idx.push_back(int'(reveal_idx));
        got_t.push_back(rel);
      end
      if (hit_mine) hit_n++;
      if (busy) busy_n++;
      if (done) done_rel = rel;
    end
    check_eq({tag, ".timeout"}, (done_rel < 0) ? 1 : 0, 0);
    check_eq({tag, ".done_at"}, done_rel, exp_done);
    check_eq({tag, ".n_reveals"}, got_idx.size(), exp_idx.size());
    nk = (got_idx.size() < exp_idx.size()) ? got_idx.size() : exp_idx.size();
    for (int k = 0; k < nk; k++) begin
      check_eq($sformatf("%s.idx[%0d]", tag, k), got_idx[k], exp_idx[k]);
      check_eq($sformatf("%s.t[%0d]", tag, k), got_t[k], exp_t[k]);
    end
    check_eq({tag, ".hits"}, hit_n, exp_hit);
    check_eq({tag, ".busy_cycles"}, busy_n, exp_done);
    check_eq({tag, ".game_over"}, int'(game_over), exp_go);
    @(negedge clk);
    check_eq({tag, ".idle_after"}, int'(busy) + int'(done) + int'(reveal_we), 0);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; start = 1'b0; start_index = 6'd0;
    mine_map = 64'd0; adj = 256'd0; flagged = 64'd0; clear_rev = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst.reveal_we", int'(reveal_we), 0);
    check_eq("rst.reveal_idx", int'(reveal_idx), 0);
    check_eq("rst.busy", int'(busy), 0);
    check_eq("rst.done", int'(done), 0);
    check_eq("rst.hit_mine", int'(hit_mine), 0);
    check_eq("rst.game_over", int'(game_over), 0);
    rst = 1'b0; clear_rev = 1'b0;

    // Full empty-board flood from the corner.
    run_req("empty0", 0);

    // Single numbered tile.
    clear_board();
    adj = 256'd0; adj[27*4 +: 4] = 4'd2;
    run_req("adj27", 27);

    // Mine in the far corner with its numbered ring.
    clear_board();
    mine_map = 64'd0; mine_map[63] = 1'b1; compute_adj();
    check_eq("corner.adj54", adj_of(54), 1);
    run_req("corner", 0);
    check_eq("corner.rev63", int'(revealed_in[63]), 0);

    // Flagged start tile.
    clear_board();
    mine_map = 64'd0; compute_adj(); flagged = 64'd0; flagged[0] = 1'b1;
    run_req("flag_start", 0);

    // Flagged zero tile inside a flood.
    clear_board();
    flagged = 64'd0; flagged[9] = 1'b1;
    run_req("flag9", 36);
    check_eq("flag9.rev9", int'(revealed_in[9]), 0);

    // Start on a tile revealed by the previous flood.
    run_req("already_rev", 36);

    // Random boards.
    for (int r = 0; r < 6; r++) begin
      int s;
      clear_board();
      for (int i = 0; i < 64; i++) begin
        mine_map[i] = ($urandom_range(0, 6) == 0);
        flagged[i]  = ($urandom_range(0, 14) == 0);
      end
      compute_adj();
      s = $urandom_range(0, 63);
      while (mine_map[s]) s = (s + 1) % 64;
      run_req($sformatf("rand%0d", r), s);
    end

    // Reset in the middle of a scan.
    clear_board();
    mine_map = 64'd0; compute_adj(); flagged = 64'd0;
    @(negedge clk); start = 1'b1; start_index = 6'd0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("midrst.busy", int'(busy), 0);
    check_eq("midrst.reveal_we", int'(reveal_we), 0);
    check_eq("midrst.reveal_idx", int'(reveal_idx), 0);
    check_eq("midrst.done", int'(done), 0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (reveal_we || busy) cnt++;
    end
    check_eq("midrst.quiet", cnt, 0);
    clear_board();
    run_req("after_rst", 0);

    // Mine hit, then a request that must be ignored.
    clear_board();
    mine_map = 64'd0; mine_map[5] = 1'b1; compute_adj();
    run_req("mine5", 5);
    check_eq("mine5.idx_hold", int'(reveal_idx), 5);
    clear_board();
    mine_map = 64'd0; compute_adj();
    @(negedge clk); start = 1'b1; start_index = 6'd0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
      if (reveal_we || busy || done) cnt++;
    end
    check_eq("gameover.ignored", cnt, 0);
    check_eq("gameover.sticky", int'(game_over), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
